// File: rtl/imm_proc_pipe_if.sv
// Handshake and data bundle for the immediate processor pipe.
interface imm_proc_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] in_pc4;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_simm;
    logic [DATA_W-1:0] out_target;
    logic              out_wrap;
    logic              out_illegal;

    modport master (
        output in_valid, in_imm, in_mode, in_pc4, out_ready,
        input  in_ready, out_valid, out_imm, out_simm, out_target, out_wrap, out_illegal
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_pc4, out_ready,
        output in_ready, out_valid, out_imm, out_simm, out_target, out_wrap, out_illegal
    );
endinterface

// File: rtl/imm_proc_pipe.sv
// Two-stage immediate extender / branch target generator with valid/ready flow control.
module imm_proc_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHIFT  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    imm_proc_pipe_if.slave bus
);
    // r_vld_pipe[0] = S1 valid, r_vld_pipe[1] = S2 valid
    logic [1:0]        r_vld_pipe;
    logic [DATA_W-1:0] r_ext;
    logic [DATA_W-1:0] r_pc4;
    logic              r_ill1;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_simm;
    logic [DATA_W-1:0] r_tgt;
    logic              r_wrap;
    logic              r_ill2;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_xfer;
    logic              w_s1_to_s2;
    logic signed [IMM_W-1:0] w_imm_s;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_up;
    logic [DATA_W-1:0] w_ext;
    logic              w_ill;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W:0]   w_sum;

    assign w_s2_adv   = !r_vld_pipe[1] || bus.out_ready;
    assign w_s1_adv   = !r_vld_pipe[0] || w_s2_adv;
    // in_ready is forced low during reset so nothing is accepted while the pipe is held clear
    assign bus.in_ready = reset_n && w_s1_adv && !flush;
    assign w_in_xfer  = bus.in_valid && bus.in_ready;
    assign w_s1_to_s2 = r_vld_pipe[0] && w_s2_adv;

    // Size casts keep DATA_W == IMM_W legal (no zero-width replications)
    assign w_imm_s = bus.in_imm;
    assign w_sext  = DATA_W'(w_imm_s);
    assign w_up    = DATA_W'(bus.in_imm) << (DATA_W - IMM_W);

    // Mode decode: reserved mode behaves like sign-extend but is flagged
    always_comb begin
        w_ext = DATA_W'(bus.in_imm);
        w_ill = 1'b0;
        case (bus.in_mode)
            2'd1: w_ext = w_sext;
            2'd2: w_ext = w_up;
            2'd3: begin
                w_ext = w_sext;
                w_ill = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_simm = r_ext << SHIFT;
    assign w_sum  = {1'b0, r_pc4} + {1'b0, w_simm};

    // Valid bits: flush squashes both stages, otherwise advance as a shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
        end else if (flush) begin
            r_vld_pipe <= '0;
        end else begin
            if (w_s1_adv) r_vld_pipe[0] <= w_in_xfer;
            if (w_s2_adv) r_vld_pipe[1] <= r_vld_pipe[0];
        end
    end

    // S1 data: loads only on an accepted input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext  <= '0;
            r_pc4  <= '0;
            r_ill1 <= 1'b0;
        end else if (w_in_xfer) begin
            r_ext  <= w_ext;
            r_pc4  <= bus.in_pc4;
            r_ill1 <= w_ill;
        end
    end

    // S2 data: loads only when a valid S1 entry moves forward
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_imm  <= '0;
            r_simm <= '0;
            r_tgt  <= '0;
            r_wrap <= 1'b0;
            r_ill2 <= 1'b0;
        end else if (w_s1_to_s2) begin
            r_imm  <= r_ext;
            r_simm <= w_simm;
            r_tgt  <= w_sum[DATA_W-1:0];
            r_wrap <= w_sum[DATA_W];
            r_ill2 <= r_ill1;
        end
    end

    assign bus.out_valid   = r_vld_pipe[1];
    assign bus.out_imm     = r_imm;
    assign bus.out_simm    = r_simm;
    assign bus.out_target  = r_tgt;
    assign bus.out_wrap    = r_wrap;
    assign bus.out_illegal = r_ill2;
endmodule

// File: tb/tb_imm_proc_pipe.sv
// Directed bench for imm_proc_pipe: modes, backpressure, flush, async reset.
module tb_imm_proc_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    imm_proc_pipe_if #(.DATA_W(32), .IMM_W(16)) bus ();

    imm_proc_pipe #(.DATA_W(32), .IMM_W(16), .SHIFT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm, input logic [31:0] pc4);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_imm   = imm;
        bus.in_pc4   = pc4;
    endtask

    logic [15:0] bp_imm [4];
    logic [31:0] bp_tgt [4];
    int nacc, ndel;

    initial begin
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
        chk("rst_out_target", 64'(bus.out_target), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // mode 1 sign-extend with target wrap
        drive(1'b1, 2'd1, 16'hFFFC, 32'h0000_1000);
        tick();
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        chk("m1_lat1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("m1_valid", 64'(bus.out_valid), 64'd1);
        chk("m1_imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
        chk("m1_simm", 64'(bus.out_simm), 64'hFFFF_FFF0);
        chk("m1_target", 64'(bus.out_target), 64'h0000_0FF0);
        chk("m1_wrap", 64'(bus.out_wrap), 64'd1);
        chk("m1_illegal", 64'(bus.out_illegal), 64'd0);
        tick();
        chk("m1_drained", 64'(bus.out_valid), 64'd0);

        // mode 0 then mode 2 back-to-back
        drive(1'b1, 2'd0, 16'h8001, 32'h0);
        tick();
        drive(1'b1, 2'd2, 16'h8001, 32'h0);
        tick();
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        chk("m0_valid", 64'(bus.out_valid), 64'd1);
        chk("m0_imm", 64'(bus.out_imm), 64'h0000_8001);
        chk("m0_wrap", 64'(bus.out_wrap), 64'd0);
        chk("m0_illegal", 64'(bus.out_illegal), 64'd0);
        tick();
        chk("m2_valid", 64'(bus.out_valid), 64'd1);
        chk("m2_imm", 64'(bus.out_imm), 64'h8001_0000);
        chk("m2_simm", 64'(bus.out_simm), 64'h0004_0000);
        chk("m2_illegal", 64'(bus.out_illegal), 64'd0);
        tick();

        // mode 3 reserved
        drive(1'b1, 2'd3, 16'h0004, 32'h0);
        tick();
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        tick();
        chk("m3_valid", 64'(bus.out_valid), 64'd1);
        chk("m3_imm", 64'(bus.out_imm), 64'h0000_0004);
        chk("m3_target", 64'(bus.out_target), 64'h0000_0010);
        chk("m3_illegal", 64'(bus.out_illegal), 64'd1);
        tick();

        // backpressure: 4 immediates, out_ready low for first 3 cycles
        bp_imm[0] = 16'h0011; bp_tgt[0] = 32'h0000_0144;
        bp_imm[1] = 16'h0022; bp_tgt[1] = 32'h0000_0188;
        bp_imm[2] = 16'h0033; bp_tgt[2] = 32'h0000_01CC;
        bp_imm[3] = 16'h0044; bp_tgt[3] = 32'h0000_0210;
        nacc = 0;
        ndel = 0;
        for (int cyc = 0; cyc < 20 && ndel < 4; cyc++) begin
            bus.out_ready = (cyc >= 3);
            if (nacc < 4) drive(1'b1, 2'd0, bp_imm[nacc], 32'h0000_0100);
            else          drive(1'b0, 2'd0, 16'h0, 32'h0);
            #1;
            if (cyc == 2) begin
                chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                chk("bp_accepted_2", 64'(nacc), 64'd2);
            end
            if (bus.out_valid) begin
                chk($sformatf("bp_imm_%0d", ndel), 64'(bus.out_imm), 64'(bp_imm[ndel]));
                chk($sformatf("bp_tgt_%0d", ndel), 64'(bus.out_target), 64'(bp_tgt[ndel]));
            end
            if (bus.out_valid && bus.out_ready) ndel++;
            if (bus.in_valid && bus.in_ready) nacc++;
            tick();
        end
        chk("bp_delivered", 64'(ndel), 64'd4);
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        bus.out_ready = 1'b1;
        tick();

        // flush with both stages full
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h0055, 32'h0);
        tick();
        drive(1'b1, 2'd0, 16'h0066, 32'h0);
        tick();
        drive(1'b1, 2'd0, 16'h0077, 32'h0);
        chk("fl_full_valid", 64'(bus.out_valid), 64'd1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_post_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        chk("fl_lat1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("fl_new_valid", 64'(bus.out_valid), 64'd1);
        chk("fl_new_imm", 64'(bus.out_imm), 64'h0000_0077);
        tick();

        // async reset while output valid
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd1, 16'h0099, 32'h0000_2000);
        tick();
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        tick();
        chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_imm", 64'(bus.out_imm), 64'd0);
        chk("ar_target", 64'(bus.out_target), 64'd0);
        chk("ar_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        drive(1'b1, 2'd1, 16'h8000, 32'h0000_0000);
        tick();
        drive(1'b0, 2'd0, 16'h0, 32'h0);
        tick();
        chk("ar_resume_valid", 64'(bus.out_valid), 64'd1);
        chk("ar_resume_imm", 64'(bus.out_imm), 64'hFFFF_8000);
        chk("ar_resume_target", 64'(bus.out_target), 64'hFFFE_0000);
        chk("ar_resume_wrap", 64'(bus.out_wrap), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imm_proc_pipe.md
Name: imm_proc_pipe

Overview:
- Pipelined, parametrised immediate processor for the decode/execute boundary.
- Extends an IMM_W-bit instruction immediate to DATA_W bits in one of four modes: zero, sign, upper (LUI), reserved.
- Produces the extended immediate, the word-shifted immediate and the branch target (pc_plus4 + shifted immediate).
- Two registered stages with valid/ready handshake, backpressure and synchronous flush for branch/exception squash.

Parameters:
- DATA_W, 32, datapath width; must satisfy DATA_W >= IMM_W.
- IMM_W, 16, instruction immediate width.
- SHIFT, 2, left shift applied for the shifted immediate (branch word offset).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all in-flight entries.
- in_valid  input  1  upstream has an immediate.
- in_ready  output  1  block accepts this cycle.
- in_imm  input  IMM_W  raw immediate.
- in_mode  input  2  0 zero-ext, 1 sign-ext, 2 upper, 3 reserved.
- in_pc4  input  DATA_W  PC+4 of the instruction.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_imm  output  DATA_W  extended immediate.
- out_simm  output  DATA_W  out_imm << SHIFT, truncated to DATA_W.
- out_target  output  DATA_W  in_pc4 + out_simm, modulo 2^DATA_W.
- out_wrap  output  1  carry out of the target addition.
- out_illegal  output  1  in_mode was 3.

Behaviour:
- Reset (async, reset_n=0): both stage valid bits = 0; out_valid=0; all data outputs = 0.
- in_ready = 0 while reset is asserted.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Data inputs are sampled only on an input transfer.
- Stage 1 (S1) registers ext, pc4 and illegal.
  - ext for mode 0: zero-extend.
  - ext for mode 1: sign-extend from in_imm[IMM_W-1].
  - ext for mode 2: in_imm << (DATA_W-IMM_W), low bits 0.
  - ext for mode 3: sign-extend, with illegal=1.
- Stage 2 (S2) registers the outputs.
  - out_imm = ext.
  - out_simm = ext << SHIFT.
  - out_target and out_wrap come from a DATA_W+1-bit add of pc4 and simm.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 per cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !flush. Combinational path from out_ready to in_ready is permitted.
- Holding: while out_valid && !out_ready, all out_* are held stable and S1 holds its contents. Both stages full is the maximum occupancy; no entry is ever dropped or duplicated.
- Flush:
  - At the clock edge, both valid bits clear. No input transfer occurs that cycle.
  - An output transfer signalled in the same cycle still counts for the downstream consumer.
  - out_valid=0 from the next cycle. Data registers may keep stale values.
- Data registers update only on a valid advance (clock-enable), not on bubbles.
- Width boundaries:
  - DATA_W == IMM_W: mode 2 yields in_imm unchanged.
  - SHIFT bits shifted past DATA_W are discarded.
  - Wrap-around of the target is reported only via out_wrap, with no other effect.
- Asynchronous reset mid-transaction discards all entries immediately.

Test Plan:
- Mode 1, in_imm=16'hFFFC, in_pc4=32'h0000_1000, out_ready=1 → two cycles later out_valid=1, out_imm=FFFF_FFFC, out_simm=FFFF_FFF0, out_target=0000_0FF0, out_wrap=1.
- Mode 0 then mode 2, in_imm=16'h8001 back-to-back → out_imm 0000_8001 then 8001_0000 on consecutive cycles; out_illegal=0 on both.
- Mode 3, in_imm=16'h0004, in_pc4=0 → out_imm=0000_0004, out_target=0000_0010, out_illegal=1.
- Backpressure: stream 4 immediates with out_ready=0 for 3 cycles → in_ready falls after 2 accepted; outputs held stable; all 4 delivered in order once out_ready=1.
- Flush with both stages full → out_valid=0 next cycle; in_valid in the flush cycle not accepted; the next input appears 2 cycles after its acceptance.
- reset_n pulsed low while out_valid=1 → out_valid and data outputs go to 0 immediately, before the next edge; normal operation resumes after release.
